subleq_memory: RTL and testbench

//  Memory responder for the subleq core bus (write/address/data, inout data). Word-addressed RAM,

---
 rtl/subleq_memory.sv | 128 ++++++++++++
 tb/tb_subleq_memory.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_memory.sv
// subleq_memory
//   Word-addressed RAM responder for the subleq core bus. Boots from a
//   streaming load port while the core is held in reset, then serves the
//   core in RUN (combinational read, clocked write) and freezes the system
//   when the core writes HALT_ADDR.
//
//   Ports:
//     clock, reset          system clock, synchronous active-high reset
//     write, address, data  core bus; data driven here only on RUN reads
//     load_valid/data/last  program image stream, accepted while load_ready
//     load_ready            high in LOAD
//     core_reset            high whenever not in RUN
//     halted                high in HALT
//     fault                 sticky out-of-range flag (SUBLEQ_MEM_FAULT_EN only)
//
//   Build option: SUBLEQ_MEM_FAULT_EN enables range checking and the fault
//   port. Without it the address wraps modulo DEPTH (DEPTH a power of two).
module subleq_memory #(
  parameter int BITS      = 8,
  parameter int DEPTH     = 16,
  parameter int HALT_ADDR = DEPTH - 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            write,
  input  logic [BITS-1:0] address,
  inout  wire  [BITS-1:0] data,
  input  logic            load_valid,
  input  logic [BITS-1:0] load_data,
  input  logic            load_last,
  output logic            load_ready,
  output logic            core_reset,
  output logic            halted
`ifdef SUBLEQ_MEM_FAULT_EN
  ,
  output logic            fault
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]      r_state;
  logic [AW-1:0]   r_load_ptr;
  logic [BITS-1:0] r_mem [DEPTH];

  logic            w_run;
  logic            w_accept;
  logic            w_load_done;
  logic            w_in_range;
  logic            w_core_wr;
  logic            w_halt_hit;
  logic            w_drive;
  logic [AW-1:0]   w_index;
  logic [BITS-1:0] w_rdata;

  assign w_run    = (r_state == ST_RUN);
  assign w_accept = load_valid && (r_state == ST_LOAD);
  // Last beat by flag or by filling the array: both cases are one transition.
  assign w_load_done = w_accept && (load_last || (r_load_ptr == AW'(DEPTH - 1)));
  assign w_index  = address[AW-1:0];

`ifdef SUBLEQ_MEM_FAULT_EN
  // Extra bit keeps the compare correct when DEPTH == 2**BITS.
  assign w_in_range = ({1'b0, address} < (BITS + 1)'(DEPTH));
`else
  assign w_in_range = 1'b1;
`endif

  assign w_core_wr  = w_run && write && w_in_range;
  // Halt is decoded on the full address, independent of the range check.
  assign w_halt_hit = w_run && write && (address == BITS'(HALT_ADDR));
  assign w_rdata    = w_in_range ? r_mem[w_index] : '0;
  assign w_drive    = w_run && !write;
  assign data       = w_drive ? w_rdata : 'z;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_LOAD;
      r_load_ptr <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_accept) r_load_ptr <= r_load_ptr + 1'b1;
          if (w_load_done) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_halt_hit) r_state <= ST_HALT;
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  // RAM contents survive reset; only the write enables are gated by it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_accept) begin
        r_mem[r_load_ptr] <= load_data;
      end else if (w_core_wr) begin
        r_mem[w_index] <= data;
      end
    end
  end

`ifdef SUBLEQ_MEM_FAULT_EN
  logic r_fault;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if (w_run && !w_in_range) begin
      r_fault <= 1'b1;
    end
  end

  assign fault = r_fault;
`endif

  assign load_ready = (r_state == ST_LOAD);
  assign core_reset = (r_state != ST_RUN);
  assign halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_subleq_memory.sv
// tb_subleq_memory
//   Directed bench for subleq_memory (BITS=8, DEPTH=16, HALT_ADDR=15).
//   A reference model (phase, load pointer, word array) advances at every
//   posedge from the bench's own inputs; a compare process checks status
//   outputs, read data and bus release each cycle, and the stimulus adds
//   literal expectations at key points.
module tb_subleq_memory;

  logic       clock = 1'b0;
  logic       reset;
  logic       write;
  logic [7:0] address;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic [7:0] tb_val;
  logic       load_ready;
  logic       core_reset;
  logic       halted;
  wire  [7:0] data;
`ifdef SUBLEQ_MEM_FAULT_EN
  logic       fault;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model: phase 0 = loading, 1 = running, 2 = halted.
  int         mdl_st = 0;
  int         mdl_ptr = 0;
  bit         mdl_fault = 0;
  logic [7:0] mdl_mem [16];
  bit         mdl_known [16];

  // The bench owns the bus whenever the memory must stay off it.
  assign data = (write || mdl_st != 1) ? tb_val : 'z;

  subleq_memory #(.BITS(8), .DEPTH(16), .HALT_ADDR(15)) dut (
    .clock      (clock),
    .reset      (reset),
    .write      (write),
    .address    (address),
    .data       (data),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .core_reset (core_reset),
    .halted     (halted)
`ifdef SUBLEQ_MEM_FAULT_EN
    ,
    .fault      (fault)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mread(input logic [7:0] a, output bit known);
`ifdef SUBLEQ_MEM_FAULT_EN
    if (a >= 16) begin
      known = 1;
      return 8'h00;
    end
`endif
    known = mdl_known[a % 16];
    return mdl_mem[a % 16];
  endfunction

  task automatic model_step();
    bit in_range;
    int idx;
    if (reset) begin
      mdl_st = 0;
      mdl_ptr = 0;
      mdl_fault = 0;
    end else if (mdl_st == 0) begin
      if (load_valid) begin
        mdl_mem[mdl_ptr] = load_data;
        mdl_known[mdl_ptr] = 1;
        if (load_last || mdl_ptr == 15) mdl_st = 1;
        mdl_ptr++;
      end
    end else if (mdl_st == 1) begin
`ifdef SUBLEQ_MEM_FAULT_EN
      in_range = (address < 16);
`else
      in_range = 1;
`endif
      idx = address % 16;
      if (!in_range) mdl_fault = 1;
      if (write && in_range) begin
        mdl_mem[idx] = tb_val;
        mdl_known[idx] = 1;
      end
      if (write && address == 8'd15) mdl_st = 2;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic peek(input string nm, input logic [7:0] exp);
    #2;
    chk(nm, data, exp);
  endtask

  task automatic read_at(input logic [7:0] a);
    write = 1'b0;
    address = a;
    tick();
  endtask

  always begin
    @(negedge clock);
    #1;
    if (chk_en) begin
      logic [7:0] e;
      bit k;
      chk("load_ready", load_ready, (mdl_st == 0));
      chk("core_reset", core_reset, (mdl_st != 1));
      chk("halted", halted, (mdl_st == 2));
`ifdef SUBLEQ_MEM_FAULT_EN
      chk("fault", fault, mdl_fault);
`endif
      if (mdl_st == 1 && !write) begin
        e = mread(address, k);
        if (k) chk("rd_data", data, e);
      end else begin
        chk("bus_free", data, tb_val);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mdl_known[i] = 0;
    reset = 1'b1; write = 1'b0; address = 8'd0; tb_val = 8'h00;
    load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
    @(negedge clock);
    tick();
    chk_en = 1;
    #2;
    chk("rst_load_ready", load_ready, 1'b1);
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_halted", halted, 1'b0);
    tick();
    reset = 1'b0;

    // 1: short image, load_last on third beat.
    beat(8'h05, 1'b0);
    beat(8'h06, 1'b0);
    #2 chk("t1_still_reset", core_reset, 1'b1);
    beat(8'h07, 1'b1);
    address = 8'd1;
    peek("t1_rd1", 8'h06);
    chk("t1_core_run", core_reset, 1'b0);
    chk("t1_not_ready", load_ready, 1'b0);
    tick();

    // 2: core write then read back.
    write = 1'b1; address = 8'd4; tb_val = 8'hFD;
    tick();
    write = 1'b0; tb_val = 8'h00;
    peek("t2_rd4", 8'hFD);
    tick();

    // 3: full 16-beat image with gaps, no load_last.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      beat(8'(8'h10 + i), 1'b0);
      if (i == 3 || i == 9) begin
        tick(); tick(); tick();
      end
    end
    address = 8'd15;
    peek("t3_rd15", 8'h1F);
    for (int i = 0; i < 16; i++) read_at(8'(i));

    // 4: write to HALT_ADDR, then a write while halted must be dropped.
    write = 1'b1; address = 8'd15; tb_val = 8'h01;
    tick();
    write = 1'b0; tb_val = 8'h00;
    #2;
    chk("t4_halted", halted, 1'b1);
    chk("t4_core_reset", core_reset, 1'b1);
    chk("t4_bus_free", data, 8'h00);
    tick();
    write = 1'b1; address = 8'd2; tb_val = 8'h77;
    tick();
    write = 1'b0; tb_val = 8'h00; address = 8'd15;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    beat(8'h99, 1'b1);
    address = 8'd15;
    peek("t4_rd15", 8'h01);
    tick();
    read_at(8'd2);
    read_at(8'd0);

    // 5: reset mid-load restarts at word 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    beat(8'h55, 1'b0);
    beat(8'h66, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    beat(8'hAA, 1'b0);
    beat(8'hBB, 1'b0);
    beat(8'hCC, 1'b1);
    address = 8'd0;
    peek("t5_rd0", 8'hAA);
    tick();
    read_at(8'd1);
    read_at(8'd2);

    // 6: out-of-range address.
    address = 8'd20;
`ifdef SUBLEQ_MEM_FAULT_EN
    peek("t6_oob_rd", 8'h00);
    tick();
    #2 chk("t6_fault", fault, 1'b1);
`else
    peek("t6_wrap_rd", 8'h14);
    tick();
`endif
    write = 1'b1; address = 8'd20; tb_val = 8'h3C;
    tick();
    write = 1'b0; tb_val = 8'h00; address = 8'd4;
`ifdef SUBLEQ_MEM_FAULT_EN
    peek("t6_rd4", 8'h14);
`else
    peek("t6_rd4", 8'h3C);
`endif
    tick();
    read_at(8'd20);

    // 7: load_last on the final word, extra beat after RUN is ignored.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) beat(8'(8'h20 + i), 1'b0);
    load_valid = 1'b1; load_data = 8'h2F; load_last = 1'b1;
    tick();
    load_data = 8'hEE;
    address = 8'd0;
    peek("t7_rd0", 8'h20);
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    for (int i = 0; i < 16; i++) read_at(8'(i));
    #2 chk("t7_running", core_reset, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
